// File: rtl/sram_act_pkg.sv
// Shared constants and helper functions for the multi-reader activation buffer.
package sram_act_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int clog2(input int value);
      int width;
      width = 32'sd1;
      for (int i = 1; i < 31; i++) begin
         width = (int'(32'd1 << i) < value) ? i + 1 : width;
      end
      return width;
   endfunction

   function automatic int onehot_to_idx(input logic [31:0] onehot);
      int idx;
      idx = 32'sd0;
      for (int i = 0; i < 32; i++) begin
         idx = idx | (onehot[i] ? i : 32'sd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Single-grant arbiter: fixed priority (lowest index) or round-robin starting after ptr.
module rr_arb
   import sram_act_pkg::*;
#(
   parameter int N    = 4,
   parameter int MODE = ARB_FIXED,
   parameter int IW   = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic [IW-1:0] next_ptr
);

   int   best_dist_s;
   int   best_idx_s;
   int   dist_s;
   logic take_s;
   logic found_s;

   // Winner is the requester closest to the search start (index 0, or ptr+1 in round-robin).
   always_comb begin
      best_dist_s = N;
      best_idx_s  = 32'sd0;
      dist_s      = 32'sd0;
      take_s      = 1'b0;
      for (int i = 0; i < N; i++) begin
         dist_s      = (MODE == ARB_RR) ? (i + 2 * N - 1 - int'(ptr)) % N : i;
         take_s      = en && req[i] && (dist_s < best_dist_s);
         best_dist_s = take_s ? dist_s : best_dist_s;
         best_idx_s  = take_s ? i : best_idx_s;
      end
      found_s = (best_dist_s < N);
      grant   = found_s ? ({{(N-1){1'b0}}, 1'b1} << best_idx_s) : {N{1'b0}};
   end

   assign grant_idx = IW'(onehot_to_idx(32'(grant)));
   assign next_ptr  = found_s ? grant_idx : ptr;

endmodule

// File: rtl/sram_act_mrd.sv
// Single-write, multi-read FWFT activation buffer; every grant to a reader is a pop of the head word.
module sram_act_mrd
   import sram_act_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int RD_NUM     = 4,
   parameter int ARB_MODE   = ARB_FIXED
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     reset,
   input  logic                     datain_val,
   output logic                     datain_rdy,
   input  logic [DATA_WIDTH-1:0]    datain,
   input  logic [RD_NUM-1:0]        dataout_rdy,
   output logic [RD_NUM-1:0]        dataout_val,
   output logic [DATA_WIDTH-1:0]    dataout,
   output logic [clog2(RD_NUM)-1:0] grant_id,
   output logic [ADDR_WIDTH:0]      count
);

   localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
   localparam int                  IW       = clog2(RD_NUM);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]       RR_INIT  = IW'(RD_NUM - 1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH:0]   count_nxt_s;
   logic [IW-1:0]         rr_ptr_r;
   logic [IW-1:0]         next_ptr_s;
   logic [IW-1:0]         grant_idx_s;
   logic [RD_NUM-1:0]     grant_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  arb_en_s;

   assign full_s     = (count_r == FULL_CNT);
   assign empty_s    = (count_r == {(ADDR_WIDTH+1){1'b0}});
   assign datain_rdy = !full_s && !reset;
   assign push_s     = datain_val && datain_rdy;
   assign arb_en_s   = !empty_s && !reset;

   rr_arb #(
      .N    (RD_NUM),
      .MODE (ARB_MODE),
      .IW   (IW)
   ) u_arb (
      .req       (dataout_rdy),
      .ptr       (rr_ptr_r),
      .en        (arb_en_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .next_ptr  (next_ptr_s)
   );

   // A grant is the pop: the reader's rdy was already high when it was granted.
   assign pop_s       = |grant_s;
   assign dataout_val = grant_s;
   assign grant_id    = grant_idx_s;
   assign dataout     = mem_r[rd_ptr_r];
   assign count       = count_r;

   // Occupancy moves only when exactly one of push/pop happens.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer, occupancy and round-robin state; synchronous clear mirrors rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r <= {ADDR_WIDTH{1'b0}};
         count_r  <= {(ADDR_WIDTH+1){1'b0}};
         rr_ptr_r <= RR_INIT;
      end else if (reset) begin
         wr_ptr_r <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r <= {ADDR_WIDTH{1'b0}};
         count_r  <= {(ADDR_WIDTH+1){1'b0}};
         rr_ptr_r <= RR_INIT;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r  <= count_nxt_s;
         rr_ptr_r <= next_ptr_s;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= datain;
      end
   end

endmodule

// File: tb/tb_sram_act_mrd.sv
// Directed bench: a fixed-priority and a round-robin instance share all inputs and are checked together.
module tb_sram_act_mrd;

   typedef struct {
      logic        val;
      logic [63:0] din;
      logic [3:0]  rdy;
      logic [3:0]  ev0;
      logic [3:0]  ev1;
      logic [1:0]  eg0;
      logic [1:0]  eg1;
      logic        dchk;
      logic [63:0] edout;
      logic [5:0]  ecnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reset;
   logic        datain_val;
   logic [63:0] datain;
   logic [3:0]  dataout_rdy;
   logic        rdy0, rdy1;
   logic [3:0]  val0, val1;
   logic [63:0] dout0, dout1;
   logic [1:0]  gid0, gid1;
   logic [5:0]  cnt0, cnt1;

   int          n_tests = 0;
   int          n_fail  = 0;
   vec_t        vecs[$];
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   sram_act_mrd #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .RD_NUM(4), .ARB_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .reset(reset), .datain_val(datain_val), .datain_rdy(rdy0),
      .datain(datain), .dataout_rdy(dataout_rdy), .dataout_val(val0), .dataout(dout0),
      .grant_id(gid0), .count(cnt0));

   sram_act_mrd #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .RD_NUM(4), .ARB_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .reset(reset), .datain_val(datain_val), .datain_rdy(rdy1),
      .datain(datain), .dataout_rdy(dataout_rdy), .dataout_val(val1), .dataout(dout1),
      .grant_id(gid1), .count(cnt1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic add(input logic val, input logic [63:0] din, input logic [3:0] rdy,
                      input logic [3:0] ev0, input logic [3:0] ev1, input logic [1:0] eg0,
                      input logic [1:0] eg1, input logic dchk, input logic [63:0] edout,
                      input logic [5:0] ecnt);
      vec_t v;
      v.val = val; v.din = din; v.rdy = rdy; v.ev0 = ev0; v.ev1 = ev1;
      v.eg0 = eg0; v.eg1 = eg1; v.dchk = dchk; v.edout = edout; v.ecnt = ecnt;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] oh;

      // Fixed priority vs round-robin (dut1 rr_ptr starts at 0 here).
      for (int k = 0; k < 6; k++)
         add(1'b1, 64'hA0 + 64'(k), 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, k > 0, 64'hA0, 6'(k));
      for (int k = 0; k < 4; k++)
         add(1'b0, 64'h0, 4'b1010, 4'b0010, (k % 2 == 1) ? 4'b1000 : 4'b0010, 2'd1,
             (k % 2 == 1) ? 2'd3 : 2'd1, 1'b1, 64'hA0 + 64'(k), 6'(6 - k));
      for (int k = 0; k < 2; k++)
         add(1'b0, 64'h0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 2'd3, 1'b1, 64'hA4 + 64'(k), 6'(2 - k));
      // All four readers requesting: round-robin rotates from rr_ptr = 3.
      for (int k = 0; k < 8; k++)
         add(1'b1, 64'hB0 + 64'(k), 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, k > 0, 64'hB0, 6'(k));
      for (int k = 0; k < 8; k++) begin
         oh = 4'b0001 << (k % 4);
         add(1'b0, 64'h0, 4'b1111, 4'b0001, oh, 2'd0, 2'(k % 4), 1'b1, 64'hB0 + 64'(k), 6'(8 - k));
      end
      for (int k = 0; k < 4; k++)
         add(1'b1, 64'hC0 + 64'(k), 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, k > 0, 64'hC0, 6'(k));
      for (int k = 0; k < 4; k++)
         add(1'b0, 64'h0, 4'b1001, 4'b0001, (k % 2 == 1) ? 4'b1000 : 4'b0001, 2'd0,
             (k % 2 == 1) ? 2'd3 : 2'd0, 1'b1, 64'hC0 + 64'(k), 6'(4 - k));

      // Power-on reset with activity on the inputs.
      rst_n = 1'b0; reset = 1'b0; datain_val = 1'b1; datain = 64'hDEAD; dataout_rdy = 4'b1111;
      repeat (3) tick();
      chk("rst_count", 64'(cnt0), 64'd0);
      chk("rst_val0", 64'(val0), 64'd0);
      chk("rst_val1", 64'(val1), 64'd0);
      chk("rst_rdy0", 64'(rdy0), 64'd1);
      chk("rst_rdy1", 64'(rdy1), 64'd1);
      chk("rst_gid", 64'(gid0), 64'd0);

      rst_n = 1'b1; datain = 64'hA5; datain_val = 1'b1; dataout_rdy = 4'b0000;
      settle();
      chk("first_push_cnt_before", 64'(cnt0), 64'd0);
      tick();
      datain_val = 1'b0;
      settle();
      chk("first_push_cnt", 64'(cnt0), 64'd1);
      chk("first_push_dout", dout0, 64'hA5);
      chk("first_push_noval", 64'(val0), 64'd0);
      dataout_rdy = 4'b0001;
      settle();
      chk("first_pop_val", 64'(val0), 64'b0001);
      tick();
      dataout_rdy = 4'b0000;
      settle();
      chk("first_pop_cnt", 64'(cnt0), 64'd0);

      // Fill to full, reject an extra push, then drain in order across the pointer wrap.
      for (int k = 0; k < 32; k++) begin
         datain_val = 1'b1; datain = 64'(k);
         tick();
      end
      datain = 64'hBAD;
      settle();
      chk("full_cnt", 64'(cnt0), 64'd32);
      chk("full_rdy", 64'(rdy0), 64'd0);
      tick();
      datain_val = 1'b0;
      settle();
      chk("full_ignore_cnt", 64'(cnt0), 64'd32);
      dataout_rdy = 4'b0001;
      for (int k = 0; k < 32; k++) begin
         settle();
         chk($sformatf("drain_dout[%0d]", k), dout0, 64'(k));
         chk($sformatf("drain_val[%0d]", k), 64'(val0), 64'b0001);
         tick();
      end
      settle();
      chk("drain_cnt", 64'(cnt0), 64'd0);
      chk("empty_noval", 64'(val0), 64'd0);
      dataout_rdy = 4'b0000;

      // Table-driven arbitration vectors.
      foreach (vecs[i]) begin
         datain_val = vecs[i].val; datain = vecs[i].din; dataout_rdy = vecs[i].rdy;
         settle();
         chk($sformatf("tbl[%0d]_val0", i), 64'(val0), 64'(vecs[i].ev0));
         chk($sformatf("tbl[%0d]_val1", i), 64'(val1), 64'(vecs[i].ev1));
         chk($sformatf("tbl[%0d]_gid0", i), 64'(gid0), 64'(vecs[i].eg0));
         chk($sformatf("tbl[%0d]_gid1", i), 64'(gid1), 64'(vecs[i].eg1));
         chk($sformatf("tbl[%0d]_cnt0", i), 64'(cnt0), 64'(vecs[i].ecnt));
         chk($sformatf("tbl[%0d]_cnt1", i), 64'(cnt1), 64'(vecs[i].ecnt));
         if (vecs[i].dchk)
            chk($sformatf("tbl[%0d]_dout", i), dout0, vecs[i].edout);
         tick();
      end
      datain_val = 1'b0; dataout_rdy = 4'b0000;

      // Simultaneous push and pop at steady occupancy 5.
      for (int k = 0; k < 5; k++) begin
         datain_val = 1'b1; datain = 64'hD0 + 64'(k);
         tick();
         sb.push_back(64'hD0 + 64'(k));
      end
      for (int k = 0; k < 10; k++) begin
         datain_val = 1'b1; datain = 64'hE0 + 64'(k); dataout_rdy = 4'b0001;
         settle();
         chk($sformatf("pp_cnt[%0d]", k), 64'(cnt0), 64'd5);
         chk($sformatf("pp_dout[%0d]", k), dout0, sb[0]);
         chk($sformatf("pp_dout1[%0d]", k), dout1, sb[0]);
         tick();
         void'(sb.pop_front());
         sb.push_back(64'hE0 + 64'(k));
      end
      datain_val = 1'b0; dataout_rdy = 4'b0000;
      settle();
      chk("pp_cnt_after", 64'(cnt0), 64'd5);

      // Full with push+pop requested: only the pop happens.
      for (int k = 0; k < 27; k++) begin
         datain_val = 1'b1; datain = 64'hF00 + 64'(k);
         tick();
         sb.push_back(64'hF00 + 64'(k));
      end
      datain_val = 1'b1; datain = 64'hFFF; dataout_rdy = 4'b0001;
      settle();
      chk("fullpp_cnt_before", 64'(cnt0), 64'd32);
      chk("fullpp_rdy", 64'(rdy0), 64'd0);
      chk("fullpp_val", 64'(val0), 64'b0001);
      chk("fullpp_dout", dout0, sb[0]);
      tick();
      void'(sb.pop_front());
      datain_val = 1'b0; dataout_rdy = 4'b0000;
      settle();
      chk("fullpp_cnt", 64'(cnt0), 64'd31);
      chk("fullpp_dout_next", dout0, sb[0]);

      // Drain to 12 words (reader 0 only, so dut1 rr_ptr ends at 0), then sync reset.
      dataout_rdy = 4'b0001;
      repeat (19) begin
         tick();
         void'(sb.pop_front());
      end
      dataout_rdy = 4'b0000;
      settle();
      chk("pre_srst_cnt", 64'(cnt0), 64'd12);
      reset = 1'b1; datain_val = 1'b1; datain = 64'h1234; dataout_rdy = 4'b1111;
      settle();
      chk("srst_rdy", 64'(rdy0), 64'd0);
      chk("srst_val0", 64'(val0), 64'd0);
      chk("srst_val1", 64'(val1), 64'd0);
      chk("srst_gid1", 64'(gid1), 64'd0);
      tick();
      settle();
      chk("srst_cnt", 64'(cnt0), 64'd0);
      chk("srst_rdy_hold", 64'(rdy0), 64'd0);
      chk("srst_val_hold", 64'(val1), 64'd0);
      reset = 1'b0; datain_val = 1'b1; datain = 64'hF0; dataout_rdy = 4'b0000;
      settle();
      chk("post_srst_rdy", 64'(rdy0), 64'd1);
      chk("post_srst_cnt0", 64'(cnt0), 64'd0);
      tick();
      datain_val = 1'b0; dataout_rdy = 4'b1111;
      settle();
      chk("post_srst_cnt1", 64'(cnt0), 64'd1);
      chk("post_srst_dout", dout0, 64'hF0);
      chk("post_srst_val0", 64'(val0), 64'b0001);
      chk("post_srst_val1", 64'(val1), 64'b0001);
      chk("post_srst_gid1", 64'(gid1), 64'd0);
      tick();
      dataout_rdy = 4'b0000;
      settle();
      chk("post_srst_pop_cnt", 64'(cnt0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
